// File: rtl/uart.sv
`timescale 1ns/1ps
// 8N1 UART: independent receiver and transmitter sharing one clock.
// The receiver synchronizes rx, confirms the start bit at its midpoint and
// samples each later bit at mid-bit. The transmitter drives tx, holding
// each bit for DIV clocks.
module uart #(
    parameter int unsigned CLK_HZ = 25000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_err
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2);

    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    // ---------------------------------------------------------------- RX
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic [2:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_done;
    logic          r_rx_err;

    logic [2:0]    w_rx_state_nxt;
    logic [CW-1:0] w_rx_cnt_nxt;
    logic [2:0]    w_rx_bit_nxt;
    logic [7:0]    w_rx_shift_nxt;
    logic [7:0]    w_rx_data_nxt;
    logic          w_rx_done_nxt;
    logic          w_rx_err_nxt;

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receiver next-state and output logic.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_done_nxt  = 1'b0;
        w_rx_err_nxt   = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                w_rx_cnt_nxt = '0;
                w_rx_bit_nxt = '0;
                if (!r_rx_sync) begin
                    w_rx_state_nxt = R_START;
                end
            end
            R_START: begin
                if (r_rx_cnt == CNT_MID) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = r_rx_sync ? R_IDLE : R_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CW'(1);
                end
            end
            R_DATA: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_bit_nxt   = '0;
                        w_rx_state_nxt = R_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CW'(1);
                end
            end
            R_STOP: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_sync) begin
                        w_rx_data_nxt  = r_rx_shift;
                        w_rx_done_nxt  = 1'b1;
                        w_rx_state_nxt = R_IDLE;
                    end else begin
                        w_rx_err_nxt   = 1'b1;
                        w_rx_state_nxt = R_WAIT;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CW'(1);
                end
            end
            R_WAIT: begin
                // A held-low line after a bad stop bit reports only once.
                w_rx_cnt_nxt = '0;
                if (r_rx_sync) begin
                    w_rx_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = R_IDLE;
                w_rx_cnt_nxt   = '0;
                w_rx_bit_nxt   = '0;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= R_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_done  <= w_rx_done_nxt;
            r_rx_err   <= w_rx_err_nxt;
        end
    end

    // ---------------------------------------------------------------- TX
    logic [1:0]    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx;
    logic          r_tx_busy;

    logic [1:0]    w_tx_state_nxt;
    logic [CW-1:0] w_tx_cnt_nxt;
    logic [2:0]    w_tx_bit_nxt;
    logic [7:0]    w_tx_shift_nxt;
    logic          w_tx_nxt;
    logic          w_tx_busy_nxt;
    logic          w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == CNT_LAST);

    // Transmitter next-state and output logic; tx is registered so it
    // already carries the value of the state being entered.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_nxt       = r_tx;
        w_tx_busy_nxt  = r_tx_busy;
        case (r_tx_state)
            T_IDLE: begin
                w_tx_nxt      = 1'b1;
                w_tx_busy_nxt = 1'b0;
                w_tx_cnt_nxt  = '0;
                w_tx_bit_nxt  = '0;
                if (tx_send) begin
                    w_tx_shift_nxt = tx_data;
                    w_tx_state_nxt = T_START;
                    w_tx_nxt       = 1'b0;
                    w_tx_busy_nxt  = 1'b1;
                end
            end
            T_START: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_nxt       = r_tx_shift[0];
                    w_tx_state_nxt = T_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
                end
            end
            T_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_bit_nxt   = '0;
                        w_tx_nxt       = 1'b1;
                        w_tx_state_nxt = T_STOP;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_nxt       = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
                end
            end
            T_STOP: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_nxt       = 1'b1;
                    w_tx_busy_nxt  = 1'b0;
                    w_tx_state_nxt = T_IDLE;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
                end
            end
            default: begin
                w_tx_state_nxt = T_IDLE;
                w_tx_nxt       = 1'b1;
                w_tx_busy_nxt  = 1'b0;
                w_tx_cnt_nxt   = '0;
            end
        endcase
    end

    // Transmitter state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;
    assign rx_data = r_rx_data;
    assign rx_done = r_rx_done;
    assign rx_err  = r_rx_err;

endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps
// Bench for uart at CLK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_uart;

    localparam int unsigned DIV = 16;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_send = 1'b0;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int done_cyc = 0;
    int stop_cyc = 0;
    logic [7:0] done_q[$];
    logic [7:0] last_rx = 8'h00;

    assign rx_line = loop_en ? tx : rx_drv;

    uart #(.CLK_HZ(16), .BAUD(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (rx_line),
        .tx      (tx),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rx_err  (rx_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Collect receiver pulses away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_q.push_back(rx_data);
            end
            if (rx_err) err_cnt++;
            if (rx_done && rx_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one 8N1 frame onto rx, starting at a falling clock edge.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            if (i == 9) stop_cyc = cyc;
            repeat (DIV) @(negedge clock);
        end
    endtask

    task automatic rx_frame_check(input logic [7:0] b);
        int d0;
        int e0;
        int lat;
        d0 = done_cnt;
        e0 = err_cnt;
        drive_rx(b, 1'b1);
        rx_drv = 1'b1;
        repeat (4) @(negedge clock);
        lat = done_cyc - stop_cyc;
        check("rx_done_count", 32'(done_cnt - d0), 32'd1);
        check("rx_err_none", 32'(err_cnt - e0), 32'd0);
        check("rx_data", 32'(rx_data), 32'(b));
        check("rx_done_latency", 32'(lat >= 9 && lat <= 13), 32'd1);
        last_rx = b;
    endtask

    // Expected line per cycle is derived from the frame bit order; a
    // stray request mid-frame and a changed tx_data must not disturb it.
    task automatic tx_frame_check(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        tx_data = b;
        tx_send = 1'b1;
        @(negedge clock);
        tx_send = 1'b0;
        tx_data = ~b;
        for (int j = 0; j < 10 * DIV; j++) begin
            check("tx_line", 32'({tx_busy, tx}), 32'({1'b1, bits[j / DIV]}));
            if (j == 40) tx_send = 1'b1;
            if (j == 41) tx_send = 1'b0;
            @(negedge clock);
        end
        check("tx_frame_end", 32'({tx_busy, tx}), 32'b01);
        @(negedge clock);
        check("tx_stays_idle", 32'({tx_busy, tx}), 32'b01);
    endtask

    initial begin
        int d0;
        int e0;
        int n0;
        int k;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_rx_err", 32'(rx_err), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Transmit: fixed A5 then random bytes
        tx_frame_check(8'hA5);
        for (int i = 0; i < 3; i++) tx_frame_check(8'($urandom_range(0, 255)));

        // Receive: fixed 3C then random bytes
        rx_frame_check(8'h3C);
        for (int i = 0; i < 4; i++) rx_frame_check(8'($urandom_range(0, 255)));

        // Short low glitch is rejected silently
        d0 = done_cnt;
        e0 = err_cnt;
        rx_drv = 1'b0;
        repeat (4) @(negedge clock);
        rx_drv = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
        rx_frame_check(8'($urandom_range(0, 255)));

        // Framing error followed by a break: one error, data held
        d0 = done_cnt;
        e0 = err_cnt;
        drive_rx(8'($urandom_range(0, 255)), 1'b0);
        repeat (100) @(negedge clock);
        rx_drv = 1'b1;
        repeat (20) @(negedge clock);
        check("break_one_err", 32'(err_cnt - e0), 32'd1);
        check("break_no_done", 32'(done_cnt - d0), 32'd0);
        check("break_data_held", 32'(rx_data), 32'(last_rx));
        rx_frame_check(8'($urandom_range(0, 255)));

        // Loopback: 00 then FF back to back, with an ignored mid-frame request
        loop_en = 1'b1;
        n0 = done_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = 8'h00;
        tx_send = 1'b1;
        @(negedge clock);
        tx_send = 1'b0;
        repeat (50) @(negedge clock);
        tx_data = 8'hFF;
        tx_send = 1'b1;
        @(negedge clock);
        tx_send = 1'b0;
        k = 0;
        while (tx_busy && k < 400) begin
            @(negedge clock);
            k++;
        end
        if (k >= 400) check("loop_busy_timeout", 32'd0, 32'd1);
        tx_send = 1'b1;
        @(negedge clock);
        tx_send = 1'b0;
        tx_data = 8'h00;
        k = 0;
        while (done_cnt - d0 < 2 && k < 500) begin
            @(negedge clock);
            k++;
        end
        repeat (40) @(negedge clock);
        check("loop_done_count", 32'(done_cnt - d0), 32'd2);
        check("loop_no_err", 32'(err_cnt - e0), 32'd0);
        if (done_q.size() >= n0 + 2) begin
            check("loop_byte0", 32'(done_q[n0]), 32'h00);
            check("loop_byte1", 32'(done_q[n0 + 1]), 32'hFF);
        end else begin
            check("loop_frames", 32'(done_q.size() - n0), 32'd2);
        end
        check("loop_tx_idle", 32'({tx_busy, tx}), 32'b01);
        loop_en = 1'b0;
        repeat (4) @(negedge clock);

        // Reset during data bit 3 aborts the frame at once
        b = 8'($urandom_range(0, 255));
        tx_data = b;
        tx_send = 1'b1;
        @(negedge clock);
        tx_send = 1'b0;
        repeat (70) @(negedge clock);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        last_rx = 8'h00;
        repeat (4) @(negedge clock);
        tx_frame_check(8'($urandom_range(0, 255)));
        rx_frame_check(8'($urandom_range(0, 255)));

        check("never_done_and_err", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLK_HZ, default 25000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Derived constant DIV = CLK_HZ / BAUD (integer division), clocks per bit (217 at the defaults).
REQ-004 Port clock  input  1  sole clock, rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port rx  input  1  serial receive line, idle high, asynchronous to clock.
REQ-007 Port tx  output  1  serial transmit line, idle high.
REQ-008 Port tx_data  input  8  byte to transmit, sampled when tx_send is accepted.
REQ-009 Port tx_send  input  1  transmit request, accepted only when tx_busy=0.
REQ-010 Port tx_busy  output  1  transmitter occupied.
REQ-011 Port rx_data  output  8  last correctly received byte, held until the next good byte.
REQ-012 Port rx_done  output  1  one-cycle pulse, new byte valid on rx_data.
REQ-013 Port rx_err  output  1  one-cycle pulse, framing error (stop bit = 0).

Function
REQ-014 The frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, each bit DIV clocks long.
REQ-015 rx SHALL pass through a 2-flop synchronizer before use; both flops SHALL reset to 1.
REQ-016 The RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP, R_WAIT.
REQ-017 R_IDLE -> R_START when the synchronized rx is 0; the bit counter clears.
REQ-018 R_START: at count DIV/2, if rx=0 go to R_DATA with the counter cleared; if rx=1 return to R_IDLE (glitch rejected, no pulse).
REQ-019 R_DATA: sample once per DIV clocks, at mid-bit, shifting LSB first; after the 8th sample go to R_STOP.
REQ-020 R_STOP: at mid-bit, if rx=1 load rx_data, pulse rx_done for one cycle, and go to R_IDLE.
REQ-021 R_STOP: at mid-bit, if rx=0 pulse rx_err for one cycle, leave rx_data unchanged, and go to R_WAIT.
REQ-022 R_WAIT: remain until the synchronized rx is 1, then go to R_IDLE (a break condition yields exactly one rx_err).
REQ-023 rx_done and rx_err SHALL never be asserted in the same cycle.
REQ-024 The TX FSM states SHALL be T_IDLE, T_START, T_DATA, T_STOP.
REQ-025 In T_IDLE with tx_send=1: latch tx_data, go to T_START, and assert tx_busy=1 and tx=0 from the next cycle.
REQ-026 The transmitter SHALL hold tx=0 for DIV clocks in T_START.
REQ-027 The transmitter SHALL send 8 data bits for DIV clocks each in T_DATA.
REQ-028 The transmitter SHALL hold tx=1 for DIV clocks in T_STOP, then return to T_IDLE with tx_busy=0.
REQ-029 The total TX frame SHALL be exactly 10*DIV clocks from the first tx=0 cycle to the first tx_busy=0 cycle.
REQ-030 tx_send while tx_busy=1 SHALL be ignored; the frame in progress and the latched byte are unaffected.
REQ-031 tx_send asserted in the first cycle with tx_busy=0 SHALL be accepted, giving back-to-back frames with no idle gap.
REQ-032 tx_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-033 RX and TX SHALL be fully independent; simultaneous activity, including loopback of tx to rx, SHALL operate correctly.
REQ-034 Bit counters SHALL be wide enough for DIV-1 and SHALL wrap to 0 at each bit boundary, with no cumulative drift.

Reset
REQ-035 While reset_n=0: tx=1, tx_busy=0, rx_data=8'h00, rx_done=0, rx_err=0, both FSMs in idle, and all counters and shift registers cleared.
REQ-036 Reset asserted mid-frame SHALL abort immediately; tx returns to 1 without completing the frame.
REQ-037 After a reset mid-frame, the receiver SHALL resynchronize on the next falling edge seen after release.

Verification (CLK_HZ=16, BAUD=1, so DIV=16)
REQ-038 Pulse tx_send with tx_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 at 16 clocks per bit; tx_busy high for 160 clocks.
REQ-039 Drive an rx frame carrying 8'h3C -> rx_data=8'h3C and a single rx_done pulse 8 clocks into the stop bit, plus the 2-cycle synchronizer delay.
REQ-040 Drive an rx low pulse of 4 clocks -> no rx_done, no rx_err, FSM back in R_IDLE.
REQ-041 Drive a frame with stop bit 0, then hold rx=0 for 100 clocks -> exactly one rx_err pulse, rx_data unchanged, and the next good frame received.
REQ-042 Loop tx to rx, send 8'h00 then 8'hFF back-to-back, with the second tx_send pulsed during the first frame and again when tx_busy=0 -> two rx_done pulses with data 00 and FF; the mid-frame request is ignored.
REQ-043 Assert reset_n=0 during data bit 3 of a TX frame -> tx=1 and tx_busy=0 asynchronously; a new frame after release is correct.
